// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Writeback scheduler and scoreboard for the 2-read/1-write integer register
// file. The single write port is shared round-robin between the ALU and LSU
// writeback requesters (valid/ready). A pending bit per register records
// writes that have been issued but have not yet landed in the register file.
// Decode uses these bits to stall on RAW hazards (rs1/rs2 busy) and on WAW
// hazards (issue_ready_o low).
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   issue_valid_i  decode issues an instruction that will write issue_rd_i
//   issue_rd_i     destination register of the issuing instruction
//   issue_ready_o  issue accepted this cycle (0 = WAW stall)
//   rs1_addr_i     decode source 1 address
//   rs2_addr_i     decode source 2 address
//   rs1_busy_o     rs1 has an outstanding write
//   rs2_busy_o     rs2 has an outstanding write
//   alu_valid_i    ALU writeback request
//   alu_rd_i       ALU destination register
//   alu_data_i     ALU result
//   alu_ready_o    ALU request granted this cycle
//   lsu_valid_i    LSU writeback request
//   lsu_rd_i       LSU destination register
//   lsu_data_i     LSU load data
//   lsu_ready_o    LSU request granted this cycle
//   wr_en_o        register file write enable (registered)
//   rd_addr_o      register file write address (registered)
//   rd_data_o      register file write data (registered)
//   pending_o      scoreboard vector, bit i = write to register i outstanding
// -----------------------------------------------------------------------------
module regfile_wb_scheduler #(
    parameter  int width_p = 32,
    parameter  int depth_p = 32,
    localparam int aw      = $clog2(depth_p)
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               issue_valid_i,
    input  logic [aw-1:0]      issue_rd_i,
    output logic               issue_ready_o,

    input  logic [aw-1:0]      rs1_addr_i,
    input  logic [aw-1:0]      rs2_addr_i,
    output logic               rs1_busy_o,
    output logic               rs2_busy_o,

    input  logic               alu_valid_i,
    input  logic [aw-1:0]      alu_rd_i,
    input  logic [width_p-1:0] alu_data_i,
    output logic               alu_ready_o,

    input  logic               lsu_valid_i,
    input  logic [aw-1:0]      lsu_rd_i,
    input  logic [width_p-1:0] lsu_data_i,
    output logic               lsu_ready_o,

    output logic               wr_en_o,
    output logic [aw-1:0]      rd_addr_o,
    output logic [width_p-1:0] rd_data_o,
    output logic [depth_p-1:0] pending_o
);

    // Which requester wins when both are valid in the same cycle.
    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

    prio_e               prio_r;
    prio_e               prio_next_s;
    logic                alu_gnt_s;
    logic                lsu_gnt_s;
    logic [aw-1:0]       gnt_rd_s;
    logic [width_p-1:0]  gnt_data_s;
    logic                wr_en_r;
    logic [aw-1:0]       rd_addr_r;
    logic [width_p-1:0]  rd_data_r;
    logic [depth_p-1:0]  pending_r;
    logic [depth_p-1:0]  pending_next_s;
    logic                issue_ready_s;
    logic                issue_fire_s;

    // Round-robin priority register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_r <= PRIO_ALU;
        end else begin
            prio_r <= prio_next_s;
        end
    end

    // Arbitration: grants depend only on valids and priority, never on
    // previous ready values, so there is no loop from ready back to valid.
    always_comb begin
        alu_gnt_s   = 1'b0;
        lsu_gnt_s   = 1'b0;
        prio_next_s = prio_r;
        if (alu_valid_i && lsu_valid_i) begin
            if (prio_r == PRIO_ALU) begin
                alu_gnt_s = 1'b1;
            end else begin
                lsu_gnt_s = 1'b1;
            end
        end else if (alu_valid_i) begin
            alu_gnt_s = 1'b1;
        end else if (lsu_valid_i) begin
            lsu_gnt_s = 1'b1;
        end else begin
            alu_gnt_s = 1'b0;
            lsu_gnt_s = 1'b0;
        end
        // The requester that was just served yields priority to the other.
        if (alu_gnt_s) begin
            prio_next_s = PRIO_LSU;
        end else if (lsu_gnt_s) begin
            prio_next_s = PRIO_ALU;
        end else begin
            prio_next_s = prio_r;
        end
    end

    // Select destination and data of the granted requester.
    always_comb begin
        gnt_rd_s   = alu_rd_i;
        gnt_data_s = alu_data_i;
        if (lsu_gnt_s) begin
            gnt_rd_s   = lsu_rd_i;
            gnt_data_s = lsu_data_i;
        end else begin
            gnt_rd_s   = alu_rd_i;
            gnt_data_s = alu_data_i;
        end
    end

    // Register file write port, one cycle after the grant. A grant to x0 is
    // consumed but produces no write and leaves address/data untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_r   <= 1'b0;
            rd_addr_r <= {aw{1'b0}};
            rd_data_r <= {width_p{1'b0}};
        end else if (alu_gnt_s || lsu_gnt_s) begin
            if (gnt_rd_s != {aw{1'b0}}) begin
                wr_en_r   <= 1'b1;
                rd_addr_r <= gnt_rd_s;
                rd_data_r <= gnt_data_s;
            end else begin
                wr_en_r   <= 1'b0;
            end
        end else begin
            wr_en_r <= 1'b0;
        end
    end

    // WAW stall: a destination with a write still outstanding cannot be
    // re-issued; x0 is never tracked and so never stalls.
    always_comb begin
        issue_ready_s = ~(issue_valid_i && (issue_rd_i != {aw{1'b0}}) && pending_r[issue_rd_i]);
        issue_fire_s  = issue_valid_i && issue_ready_s && (issue_rd_i != {aw{1'b0}});
    end

    // Scoreboard next state: the clear for the write being performed this
    // cycle is applied first so a same-edge issue to that register wins.
    always_comb begin
        pending_next_s = pending_r;
        if (wr_en_r) begin
            pending_next_s[rd_addr_r] = 1'b0;
        end else begin
            pending_next_s = pending_r;
        end
        if (issue_fire_s) begin
            pending_next_s[issue_rd_i] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
        pending_next_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_r <= {depth_p{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign alu_ready_o   = alu_gnt_s;
    assign lsu_ready_o   = lsu_gnt_s;
    assign issue_ready_o = issue_ready_s;
    assign rs1_busy_o    = (rs1_addr_i != {aw{1'b0}}) && pending_r[rs1_addr_i];
    assign rs2_busy_o    = (rs2_addr_i != {aw{1'b0}}) && pending_r[rs2_addr_i];
    assign wr_en_o       = wr_en_r;
    assign rd_addr_o     = rd_addr_r;
    assign rd_data_o     = rd_data_r;
    assign pending_o     = pending_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wb_scheduler. Directed scenarios followed by random
// traffic. Expected register-file writes are queued when a grant is predicted
// and a separate monitor pops and compares them whenever wr_en_o is high.
// The reference model keeps a set of outstanding registers and a "last served"
// requester and applies the writeback/scoreboard rules cycle by cycle.
// -----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        issue_ready_o;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        alu_ready_o;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        lsu_ready_o;
    logic        wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [31:0] pending_o;

    regfile_wb_scheduler #(.width_p(32), .depth_p(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
        .wr_en_o(wr_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    // reference model state
    bit [31:0] m_pend;       // set of registers with a write outstanding
    bit        m_last_alu;   // 1: most recent grant went to the ALU
    bit        m_clr_v;      // a write was granted last cycle ...
    logic [4:0] m_clr_rd;    // ... to this register (lands at end of this cycle)
    bit        m_alu_g;
    bit        m_lsu_g;

    // observations captured mid-cycle by step()
    logic        o_alu_rdy, o_lsu_rdy, o_iss_rdy, o_b1, o_wr_en;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic [31:0] o_pend;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
        alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_data_i = 32'd0;
        lsu_valid_i = 1'b0; lsu_rd_i = 5'd0; lsu_data_i = 32'd0;
    endtask

    task automatic model_reset();
        m_pend = 32'd0;
        m_last_alu = 1'b0;
        m_clr_v = 1'b0;
        m_clr_rd = 5'd0;
    endtask

    // One clock cycle: inputs already driven (at posedge+1). Checks combinational
    // outputs at the falling edge, predicts writes, advances the model.
    task automatic step();
        bit e_ar, e_lr, e_ir, e_b1, e_b2;
        bit [31:0] nxt;
        @(negedge clk_i);
        o_alu_rdy = alu_ready_o; o_lsu_rdy = lsu_ready_o; o_iss_rdy = issue_ready_o;
        o_b1 = rs1_busy_o; o_wr_en = wr_en_o; o_rd_addr = rd_addr_o;
        o_rd_data = rd_data_o; o_pend = pending_o;
        // the requester not served most recently wins a tie
        e_ar = alu_valid_i && (!lsu_valid_i || !m_last_alu);
        e_lr = lsu_valid_i && (!alu_valid_i || m_last_alu);
        e_ir = !(issue_valid_i && issue_rd_i != 5'd0 && m_pend[issue_rd_i]);
        e_b1 = (rs1_addr_i != 5'd0) && m_pend[rs1_addr_i];
        e_b2 = (rs2_addr_i != 5'd0) && m_pend[rs2_addr_i];
        chk("alu_ready", 64'(alu_ready_o), 64'(e_ar));
        chk("lsu_ready", 64'(lsu_ready_o), 64'(e_lr));
        chk("issue_ready", 64'(issue_ready_o), 64'(e_ir));
        chk("rs1_busy", 64'(rs1_busy_o), 64'(e_b1));
        chk("rs2_busy", 64'(rs2_busy_o), 64'(e_b2));
        chk("pending", 64'(pending_o), 64'(m_pend));
        if (e_ar && alu_rd_i != 5'd0) exp_q.push_back('{rd: alu_rd_i, d: alu_data_i});
        if (e_lr && lsu_rd_i != 5'd0) exp_q.push_back('{rd: lsu_rd_i, d: lsu_data_i});
        nxt = m_pend;
        if (m_clr_v) nxt[m_clr_rd] = 1'b0;
        if (issue_valid_i && e_ir && issue_rd_i != 5'd0) nxt[issue_rd_i] = 1'b1;
        m_pend = nxt;
        m_clr_v  = (e_ar && alu_rd_i != 5'd0) || (e_lr && lsu_rd_i != 5'd0);
        m_clr_rd = e_lr ? lsu_rd_i : alu_rd_i;
        if (e_ar || e_lr) m_last_alu = e_ar;
        m_alu_g = e_ar;
        m_lsu_g = e_lr;
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every register-file write must match the oldest predicted write.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk_i);
            #3;
            if (rst_ni === 1'b1 && wr_en_o === 1'b1) begin
                chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk("wr_addr", 64'(rd_addr_o), 64'(w.rd));
                    chk("wr_data", 64'(rd_data_o), 64'(w.d));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [4:0]  a_rd, l_rd;
        logic [31:0] a_d, l_d, d7, d4;
        bit          ra_v, rl_v;
        logic [4:0]  ra_rd, rl_rd;
        logic [31:0] ra_d, rl_d;

        rst_ni = 1'b0;
        idle();
        model_reset();
        #2;
        chk("rst_wr_en", 64'(wr_en_o), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr_o), 64'd0);
        chk("rst_rd_data", 64'(rd_data_o), 64'd0);
        chk("rst_pending", 64'(pending_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // both requesters valid for 4 cycles: ALU, LSU, ALU, LSU
        a_rd = 5'd10; a_d = $urandom; l_rd = 5'd20; l_d = $urandom;
        for (int i = 0; i < 4; i++) begin
            idle();
            alu_valid_i = 1'b1; alu_rd_i = a_rd; alu_data_i = a_d;
            lsu_valid_i = 1'b1; lsu_rd_i = l_rd; lsu_data_i = l_d;
            step();
            chk("alt_alu", 64'(o_alu_rdy), 64'((i % 2) == 0));
            chk("alt_lsu", 64'(o_lsu_rdy), 64'((i % 2) == 1));
            if (m_alu_g) begin a_rd = a_rd + 5'd1; a_d = $urandom; end
            if (m_lsu_g) begin l_rd = l_rd + 5'd1; l_d = $urandom; end
        end
        idle(); step(); step();

        // issue rd5, ALU writes 0xDEADBEEF, busy drops two cycles after grant
        idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd5; step();
        idle(); alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEAD_BEEF; rs1_addr_i = 5'd5; step();
        chk("t5_busy_n", 64'(o_b1), 64'd1);
        idle(); rs1_addr_i = 5'd5; step();
        chk("t5_wr_en", 64'(o_wr_en), 64'd1);
        chk("t5_addr", 64'(o_rd_addr), 64'd5);
        chk("t5_data", 64'(o_rd_data), 64'hDEAD_BEEF);
        chk("t5_busy_n1", 64'(o_b1), 64'd1);
        step();
        chk("t5_busy_n2", 64'(o_b1), 64'd0);

        // WAW stall on rd7 including the cycle the write is performed
        d7 = $urandom;
        idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd7; step();
        chk("t7_first", 64'(o_iss_rdy), 64'd1);
        step();
        chk("t7_stall", 64'(o_iss_rdy), 64'd0);
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = d7; step();
        chk("t7_stall_gnt", 64'(o_iss_rdy), 64'd0);
        idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd7; step();
        chk("t7_stall_wr", 64'(o_iss_rdy), 64'd0);
        chk("t7_wr_en", 64'(o_wr_en), 64'd1);
        step();
        chk("t7_release", 64'(o_iss_rdy), 64'd1);
        idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd0; step();
        chk("t0_issue", 64'(o_iss_rdy), 64'd1);
        idle(); step();
        chk("t7_pend", 64'(o_pend[7]), 64'd1);
        chk("t0_pend", 64'(o_pend[0]), 64'd0);
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = d7; step();
        idle(); step(); step();

        // LSU write to x0: accepted, no write, address/data hold
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_data_i = 32'd1; step();
        chk("x0_ready", 64'(o_lsu_rdy), 64'd1);
        idle(); step();
        chk("x0_wr_en", 64'(o_wr_en), 64'd0);
        chk("x0_addr", 64'(o_rd_addr), 64'd7);
        chk("x0_data", 64'(o_rd_data), 64'(d7));

        // issue rd4 on the same edge as the (no-op) clear of rd4: set wins
        d4 = $urandom;
        alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = d4; step();
        idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd4; step();
        chk("t4_ready", 64'(o_iss_rdy), 64'd1);
        chk("t4_wr_en", 64'(o_wr_en), 64'd1);
        chk("t4_addr", 64'(o_rd_addr), 64'd4);
        idle(); step();
        chk("t4_pend", 64'(o_pend[4]), 64'd1);
        alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = d4; step();
        idle(); step(); step();

        // random traffic; requesters hold their request until granted
        ra_v = 1'b0; rl_v = 1'b0; ra_rd = 5'd0; rl_rd = 5'd0; ra_d = 32'd0; rl_d = 32'd0;
        for (int c = 0; c < 400; c++) begin
            if (!ra_v && $urandom_range(0, 99) < 60) begin
                ra_v = 1'b1; ra_rd = 5'($urandom_range(0, 7)); ra_d = $urandom;
            end
            if (!rl_v && $urandom_range(0, 99) < 60) begin
                rl_v = 1'b1; rl_rd = 5'($urandom_range(0, 7)); rl_d = $urandom;
            end
            issue_valid_i = 1'($urandom_range(0, 1));
            issue_rd_i = 5'($urandom_range(0, 7));
            rs1_addr_i = 5'($urandom_range(0, 7));
            rs2_addr_i = 5'($urandom_range(0, 7));
            alu_valid_i = ra_v; alu_rd_i = ra_rd; alu_data_i = ra_d;
            lsu_valid_i = rl_v; lsu_rd_i = rl_rd; lsu_data_i = rl_d;
            step();
            if (m_alu_g) ra_v = 1'b0;
            if (m_lsu_g) rl_v = 1'b0;
        end
        idle(); step(); step(); step();

        // asynchronous reset while a write is on the port
        issue_valid_i = 1'b1; issue_rd_i = 5'd9; step();
        idle(); alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = $urandom; step();
        idle();
        chk("mid_wr_en", 64'(wr_en_o), 64'd1);
        chk("mid_pend9", 64'(pending_o[9]), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_wr_en", 64'(wr_en_o), 64'd0);
        chk("arst_pending", 64'(pending_o), 64'd0);
        chk("arst_addr", 64'(rd_addr_o), 64'd0);
        exp_q.delete();
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        alu_valid_i = 1'b1; alu_rd_i = 5'd11; alu_data_i = $urandom;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd12; lsu_data_i = $urandom;
        step();
        chk("post_rst_alu", 64'(o_alu_rdy), 64'd1);
        chk("post_rst_lsu", 64'(o_lsu_rdy), 64'd0);
        idle(); step(); step(); step();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
